bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TENURE, default 64: maximum DMA tenure in clk_p cycles; range 2..255; used only with ARB_TENURE_LIMIT_EN.
REQ-002 clk_p  input  1  bus clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 cpu_cyc_i  input  1  CPU local Wishbone cycle strobe.
REQ-005 cpu_ack_i  input  1  acknowledge of the current CPU transaction.
REQ-006 dma_req_i  input  2  bus requests from DMA masters 0 and 1.
REQ-007 dma_cyc_i  input  2  Wishbone cycle strobes of DMA masters 0 and 1.
REQ-008 cpu_gnt_o  output  1  CPU bus grant; drives the CPU grant input; registered.
REQ-009 dma_gnt_o  output  2  DMA grants, one-hot or zero; registered.
REQ-010 owner_o  output  2  current owner: 00 CPU, 01 DMA0, 10 DMA1, 11 gap; registered.

Function
REQ-011 FSM states: CPU, GAP, DMA0, DMA1; outputs are decoded from state only (Moore).
REQ-012 At most one of cpu_gnt_o, dma_gnt_o[0], dma_gnt_o[1] is high in any cycle.
REQ-013 CPU -> GAP when any dma_req_i is high and (cpu_cyc_i==0 or cpu_ack_i==1); target DMA latched at the same edge.
REQ-014 Target selection: if both requests are high, pick the master other than last_dma; otherwise pick the requesting master.
REQ-015 GAP lasts exactly one cycle with all grants low, then enters the latched target state.
REQ-016 Entry to GAP from a DMA state sets target = other DMA if its request is high, else CPU.
REQ-017 DMAk -> GAP when dma_req_i[k]==0 and dma_cyc_i[k]==0; last_dma <= k on that edge.
REQ-018 DMAk with dma_req_i[k]==0 but dma_cyc_i[k]==1 holds the grant until the cycle ends.
REQ-019 Latency: dma_req_i rises in cycle n with the CPU idle -> cpu_gnt_o low from n+1, dma_gnt_o high from n+2.
REQ-020 Release latency: DMA drops req and cyc in cycle n -> dma_gnt_o low from n+1, next grant high from n+2.
REQ-021 A request dropped while in GAP does not cancel the latched target; the target state releases at the next evaluation per REQ-017.
REQ-022 A grant is never revoked while the owning master's cyc is high.

Reset
REQ-023 While rst_n is low: state CPU, cpu_gnt_o=1, dma_gnt_o=00, owner_o=00, last_dma=1, tenure counter=0.
REQ-024 Reset asserted mid-DMA-tenure returns grant to the CPU immediately (asynchronously); no GAP cycle is issued.
REQ-025 After rst_n rises, the first evaluation follows REQ-013 in the next clk_p edge.

Configuration
REQ-026 Macro ARB_TENURE_LIMIT_EN defined: 8-bit counter clears on entry to DMAk and increments each cycle in DMAk, saturating at TENURE-1.
REQ-027 With ARB_TENURE_LIMIT_EN, counter==TENURE-1 and dma_cyc_i[k]==0 forces DMAk -> GAP even if dma_req_i[k]==1; target per REQ-016, and last_dma <= k.
REQ-028 With ARB_TENURE_LIMIT_EN, a forced release while dma_cyc_i[k]==1 waits for dma_cyc_i[k] low (REQ-022 precedence).
REQ-029 Without ARB_TENURE_LIMIT_EN: no counter logic; tenure is unbounded; REQ-017 is the only release condition.

Verification
REQ-030 Reset released, no requests, 100 cycles -> cpu_gnt_o=1, dma_gnt_o=00, owner_o=00 throughout.
REQ-031 cpu_cyc_i=1 with no ack, dma_req_i=01 -> grant held by CPU; cpu_ack_i pulse at cycle n -> cpu_gnt_o=0 at n+1, owner_o=11, dma_gnt_o=01 at n+2.
REQ-032 dma_req_i=11 from CPU state with last_dma=1 -> DMA0 granted first; DMA0 releases -> one GAP cycle -> dma_gnt_o=10 without a CPU slot.
REQ-033 DMA1 drops req with dma_cyc_i[1]=1 for 5 more cycles -> dma_gnt_o=10 held 5 cycles, released one cycle after cyc falls, cpu_gnt_o=1 two cycles after.
REQ-034 ARB_TENURE_LIMIT_EN, TENURE=16, DMA0 holds req with cyc low -> forced GAP after 16 cycles in DMA0, cpu_gnt_o=1 next cycle, DMA0 regranted after CPU idle per REQ-013.
REQ-035 rst_n pulsed low during DMA1 tenure -> same-cycle dma_gnt_o=00, cpu_gnt_o=1, owner_o=00, last_dma=1.

Source files
------------

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Arbitrates a shared Wishbone bus between a CPU (the default owner) and two
// DMA masters. Every handover goes through one GAP cycle in which no grant is
// asserted. A DMA master keeps the bus while its cycle strobe is high. When both
// masters request at once, the one that did not own the bus last is chosen.
//
// Optional feature (macro ARB_TENURE_LIMIT_EN): an 8-bit tenure counter caps a
// DMA ownership at TENURE cycles. Once the cap is reached, the master gives the
// bus up as soon as its cycle strobe is low, even while it still requests.
// Without the macro a DMA tenure is unbounded.
//
// Parameters
//   TENURE     maximum DMA tenure in clk_p cycles (2..255), limit build only
// Ports
//   clk_p      bus clock, rising edge
//   rst_n      asynchronous active-low reset
//   cpu_cyc_i  CPU Wishbone cycle strobe
//   cpu_ack_i  acknowledge of the current CPU transaction
//   dma_req_i  bus requests from DMA masters 1:0
//   dma_cyc_i  cycle strobes from DMA masters 1:0
//   cpu_gnt_o  CPU bus grant
//   dma_gnt_o  DMA grants, one-hot or zero
//   owner_o    current owner: 00 CPU, 01 DMA0, 10 DMA1, 11 gap
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int unsigned TENURE = 64
) (
   input  logic       clk_p,
   input  logic       rst_n,
   input  logic       cpu_cyc_i,
   input  logic       cpu_ack_i,
   input  logic [1:0] dma_req_i,
   input  logic [1:0] dma_cyc_i,
   output logic       cpu_gnt_o,
   output logic [1:0] dma_gnt_o,
   output logic [1:0] owner_o
);

   // The encoding matches owner_o, so the owner output is the state register.
   typedef enum logic [1:0] {
      ST_CPU  = 2'b00,
      ST_DMA0 = 2'b01,
      ST_DMA1 = 2'b10,
      ST_GAP  = 2'b11
   } state_t;

   if (TENURE < 2 || TENURE > 255) begin : g_tenure_range
      $error("bus_arbiter: TENURE must lie in 2..255");
   end

   state_t state, state_nxt;
   state_t target, target_nxt;      // state entered when GAP ends
   logic   last_dma, last_dma_nxt;  // DMA master that most recently gave up the bus
   logic   force_rel;               // tenure cap reached in the current DMA state

`ifdef ARB_TENURE_LIMIT_EN
   logic [7:0] tenure_cnt;
   logic       tenure_done;

   assign tenure_done = (tenure_cnt == 8'(TENURE - 1));

   // Every DMA state is entered from GAP, so clearing outside DMA states gives
   // a count of zero in the first cycle of each tenure. It saturates at the cap.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         tenure_cnt <= '0;
      end else if (state != ST_DMA0 && state != ST_DMA1) begin
         tenure_cnt <= '0;
      end else if (!tenure_done) begin
         tenure_cnt <= tenure_cnt + 8'd1;
      end
   end

   assign force_rel = tenure_done;
`else
   assign force_rel = 1'b0;
`endif

   // State register. The asynchronous reset hands the bus back to the CPU
   // immediately, with no GAP cycle.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge no matter how the blocks are ordered.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_CPU;
         target   <= ST_CPU;
         last_dma <= 1'b1;
      end else begin
         state    <= state_nxt;
         target   <= target_nxt;
         last_dma <= last_dma_nxt;
      end
   end

   // Next-state logic. A DMA master is released only while its cycle strobe is
   // low, so a grant is never pulled from under a running bus cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_nxt    = state;
      target_nxt   = target;
      last_dma_nxt = last_dma;
      unique case (state)
         ST_CPU: begin
            if (|dma_req_i && (!cpu_cyc_i || cpu_ack_i)) begin
               state_nxt = ST_GAP;
               if (&dma_req_i) begin
                  target_nxt = last_dma ? ST_DMA0 : ST_DMA1;
               end else begin
                  target_nxt = dma_req_i[0] ? ST_DMA0 : ST_DMA1;
               end
            end
         end
         // The latched target is kept even if its request drops during GAP.
         ST_GAP: begin
            state_nxt = target;
         end
         ST_DMA0: begin
            if (!dma_cyc_i[0] && (!dma_req_i[0] || force_rel)) begin
               state_nxt    = ST_GAP;
               target_nxt   = dma_req_i[1] ? ST_DMA1 : ST_CPU;
               last_dma_nxt = 1'b0;
            end
         end
         ST_DMA1: begin
            if (!dma_cyc_i[1] && (!dma_req_i[1] || force_rel)) begin
               state_nxt    = ST_GAP;
               target_nxt   = dma_req_i[0] ? ST_DMA0 : ST_CPU;
               last_dma_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_CPU;
         end
      endcase
   end

   // Moore outputs, decoded from the state register only. The state encoding
   // makes the grants mutually exclusive.
   always_comb begin
      cpu_gnt_o = (state == ST_CPU);
      dma_gnt_o = {state == ST_DMA1, state == ST_DMA0};
      owner_o   = state;
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed testbench for bus_arbiter with TENURE = 16. The inputs change 1 ns
// after a rising edge, and the outputs are sampled at that same point, away
// from the edge. If ARB_TENURE_LIMIT_EN is defined for the bench as well as for
// the RTL, the tenure-limit sequence runs. Otherwise the unbounded-tenure
// sequence runs.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   logic       clk_p = 1'b0;
   logic       rst_n = 1'b0;
   logic       cpu_cyc = 1'b0;
   logic       cpu_ack = 1'b0;
   logic [1:0] dma_req = 2'b00;
   logic [1:0] dma_cyc = 2'b00;
   logic       cpu_gnt;
   logic [1:0] dma_gnt;
   logic [1:0] owner;

   int checks = 0;
   int errors = 0;

   always #5 clk_p = ~clk_p;

   bus_arbiter #(.TENURE(16)) dut (
      .clk_p     (clk_p),
      .rst_n     (rst_n),
      .cpu_cyc_i (cpu_cyc),
      .cpu_ack_i (cpu_ack),
      .dma_req_i (dma_req),
      .dma_cyc_i (dma_cyc),
      .cpu_gnt_o (cpu_gnt),
      .dma_gnt_o (dma_gnt),
      .owner_o   (owner)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Compares the whole output bundle {cpu_gnt, dma_gnt, owner}.
   task automatic expect_bus(input string tag, input logic c, input logic [1:0] d,
                             input logic [1:0] o);
      check(tag, {3'b000, cpu_gnt, dma_gnt, owner}, {3'b000, c, d, o});
   endtask

   task automatic exp_cpu(input string tag);
      expect_bus(tag, 1'b1, 2'b00, 2'b00);
   endtask
   task automatic exp_gap(input string tag);
      expect_bus(tag, 1'b0, 2'b00, 2'b11);
   endtask
   task automatic exp_dma0(input string tag);
      expect_bus(tag, 1'b0, 2'b01, 2'b01);
   endtask
   task automatic exp_dma1(input string tag);
      expect_bus(tag, 1'b0, 2'b10, 2'b10);
   endtask

   // Advances one clock and checks that at most one grant is high.
   task automatic step();
      @(posedge clk_p);
      #1;
      check("grant_exclusive", {7'b0, ($countones({cpu_gnt, dma_gnt}) <= 1)}, 8'd1);
   endtask

   initial begin
      // The outputs during reset, before and across a clock edge.
      #2;
      exp_cpu("reset_initial");
      step();
      exp_cpu("reset_edge");
      rst_n = 1'b1;

      // With no requests the CPU keeps the bus.
      for (int i = 0; i < 100; i++) begin
         step();
         exp_cpu("idle_cpu");
      end

      // Both masters request after reset (last_dma=1): DMA0 gets the bus first,
      // then DMA1 follows through a single GAP cycle with no CPU slot.
      dma_req = 2'b11;
      step(); exp_gap("both_gap");
      step(); exp_dma0("both_first_dma0");
      dma_cyc = 2'b01;
      step(); exp_dma0("dma0_hold_a");
      step(); exp_dma0("dma0_hold_b");
      dma_req = 2'b10;
      dma_cyc = 2'b00;
      step(); exp_gap("dma0_release_gap");
      step(); exp_dma1("dma1_direct");

      // DMA1 drops its request while its cycle strobe stays high for 5 cycles.
      dma_cyc = 2'b10;
      step(); exp_dma1("dma1_cyc_on");
      dma_req = 2'b00;
      for (int i = 0; i < 5; i++) begin
         step();
         exp_dma1("dma1_cyc_hold");
      end
      dma_cyc = 2'b00;
      step(); exp_gap("dma1_release_gap");
      step(); exp_cpu("dma1_cpu_back");

      // A busy CPU holds the bus until its acknowledge arrives.
      cpu_cyc = 1'b1;
      dma_req = 2'b01;
      for (int i = 0; i < 3; i++) begin
         step();
         exp_cpu("cpu_busy_hold");
      end
      cpu_ack = 1'b1;
      step(); exp_gap("ack_gap");
      cpu_ack = 1'b0;
      cpu_cyc = 1'b0;
      step(); exp_dma0("ack_dma0");
      dma_req = 2'b00;
      step(); exp_gap("ack_release_gap");
      step(); exp_cpu("ack_cpu_back");

      // With last_dma=0, simultaneous requests go to DMA1 first.
      dma_req = 2'b11;
      step(); exp_gap("rr_gap");
      step(); exp_dma1("rr_pick_dma1");
      dma_req = 2'b01;
      step(); exp_gap("rr_switch_gap");
      step(); exp_dma0("rr_then_dma0");
      dma_req = 2'b00;
      step(); exp_gap("rr_release_gap");
      step(); exp_cpu("rr_cpu_back");

      // A request dropped during GAP still enters the latched target.
      dma_req = 2'b10;
      step(); exp_gap("latch_gap");
      dma_req = 2'b00;
      step(); exp_dma1("latch_target_dma1");
      step(); exp_gap("latch_release_gap");
      step(); exp_cpu("latch_cpu_back");

      // One DMA0 tenure leaves last_dma=0 before the reset test.
      dma_req = 2'b01;
      step(); exp_gap("prep_gap");
      step(); exp_dma0("prep_dma0");
      dma_req = 2'b00;
      step(); exp_gap("prep_release_gap");
      step(); exp_cpu("prep_cpu_back");

      // Reset in the middle of a DMA1 tenure returns the bus at once and
      // restores last_dma=1, so simultaneous requests then go to DMA0.
      dma_req = 2'b10;
      dma_cyc = 2'b10;
      step(); exp_gap("pre_reset_gap");
      step(); exp_dma1("pre_reset_dma1");
      #2;
      rst_n = 1'b0;
      #1;
      exp_cpu("async_reset");
      dma_req = 2'b11;
      dma_cyc = 2'b00;
      step(); exp_cpu("reset_held");
      #2;
      rst_n = 1'b1;
      step(); exp_gap("post_reset_gap");
      step(); exp_dma0("post_reset_last_dma");
      dma_req = 2'b00;
      step(); exp_gap("post_reset_release");
      step(); exp_cpu("post_reset_cpu");

      // DMA0 keeps requesting with its cycle strobe low.
      dma_req = 2'b01;
      step(); exp_gap("ten_gap");
      step(); exp_dma0("ten_entry");
`ifdef ARB_TENURE_LIMIT_EN
      for (int i = 0; i < 15; i++) begin
         step();
         exp_dma0("ten_hold");
      end
      step(); exp_gap("ten_forced_gap");
      step(); exp_cpu("ten_cpu_slot");
      step(); exp_gap("ten_regrant_gap");
      step(); exp_dma0("ten_regrant");
      // A cap reached while the cycle strobe is high waits for it to fall.
      dma_cyc = 2'b01;
      for (int i = 0; i < 20; i++) begin
         step();
         exp_dma0("ten_cyc_hold");
      end
      dma_cyc = 2'b00;
      step(); exp_gap("ten_cyc_release");
      dma_req = 2'b00;
      step(); exp_cpu("ten_cpu_back");
`else
      for (int i = 0; i < 30; i++) begin
         step();
         exp_dma0("unbounded_hold");
      end
      dma_req = 2'b00;
      step(); exp_gap("unbounded_release");
      step(); exp_cpu("unbounded_cpu_back");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
